// File: rtl/condicionador_pkg.sv
// rtl/condicionador_pkg.sv - shared state codes, default parameters and helpers for the button conditioner
package condicionador_pkg;

  typedef enum logic [1:0] {
    OCIOSO        = 2'b00,
    FILTRANDO     = 2'b01,
    ESPERA_SOLTAR = 2'b10,
    RESERVADO     = 2'b11
  } estado_t;

  localparam int DEBOUNCE_CYCLES_PADRAO = 3;
  localparam int TIMEOUT_CYCLES_PADRAO  = 5000;

  // True when exactly one button of the group is pressed
  function automatic logic eh_one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// rtl/sincronizador_2ff.sv - two-flop synchronizer for the raw asynchronous buttons
module sincronizador_2ff #(
  parameter int LARGURA = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  logic [LARGURA-1:0] estagio1;

  // First stage may go metastable; second stage gives it a full cycle to settle
  always_ff @(posedge clock) begin
    if (reset) begin
      estagio1 <= '0;
      q        <= '0;
    end else begin
      estagio1 <= d;
      q        <= estagio1;
    end
  end

endmodule

// File: rtl/condicionador_botoes.sv
// rtl/condicionador_botoes.sv - debounce, single-press detection and idle timeout for four push buttons
module condicionador_botoes #(
  parameter int DEBOUNCE_CYCLES = condicionador_pkg::DEBOUNCE_CYCLES_PADRAO,
  parameter int TIMEOUT_CYCLES  = condicionador_pkg::TIMEOUT_CYCLES_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] botoes,
  output logic [3:0] jogada,
  output logic       tem_jogada,
  output logic       jogada_invalida,
  output logic       timeout,
  output logic [1:0] db_estado
);
  import condicionador_pkg::*;

  // Compare "count before this sample" against target-1 so the counter never needs to pass the target
  localparam logic [7:0]  DB_ULTIMO = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] TO_ULTIMO = 16'(TIMEOUT_CYCLES - 1);

  logic [3:0]  s;
  estado_t     estado, estado_prox;
  logic [3:0]  cand, cand_prox;
  logic [7:0]  cnt_estavel, cnt_estavel_prox;
  logic [15:0] cnt_ocioso, cnt_ocioso_prox;
  logic [3:0]  jogada_prox;
  logic        tem_jogada_prox, invalida_prox, timeout_prox;

  sincronizador_2ff #(.LARGURA(4)) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (botoes),
    .q     (s)
  );

  // State, candidate, counters and all outputs are registered together
  always_ff @(posedge clock) begin
    if (reset) begin
      estado          <= OCIOSO;
      cand            <= 4'd0;
      cnt_estavel     <= 8'd0;
      cnt_ocioso      <= 16'd0;
      jogada          <= 4'd0;
      tem_jogada      <= 1'b0;
      jogada_invalida <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      estado          <= estado_prox;
      cand            <= cand_prox;
      cnt_estavel     <= cnt_estavel_prox;
      cnt_ocioso      <= cnt_ocioso_prox;
      jogada          <= jogada_prox;
      tem_jogada      <= tem_jogada_prox;
      jogada_invalida <= invalida_prox;
      timeout         <= timeout_prox;
    end
  end

  // Next-state and next-output decode; pulses default low so they last one cycle
  always_comb begin
    estado_prox      = estado;
    cand_prox        = cand;
    cnt_estavel_prox = cnt_estavel;
    cnt_ocioso_prox  = cnt_ocioso;
    jogada_prox      = jogada;
    tem_jogada_prox  = 1'b0;
    invalida_prox    = 1'b0;
    timeout_prox     = 1'b0;

    case (estado)
      OCIOSO: begin
        if (enable && (s != 4'd0)) begin
          cand_prox        = s;
          cnt_estavel_prox = 8'd1;
          cnt_ocioso_prox  = 16'd0;
          estado_prox      = FILTRANDO;
        end else if (enable) begin
          if (cnt_ocioso >= TO_ULTIMO) begin
            timeout_prox    = 1'b1;
            cnt_ocioso_prox = 16'd0;
          end else begin
            cnt_ocioso_prox = cnt_ocioso + 16'd1;
          end
        end else begin
          cnt_ocioso_prox = 16'd0;
        end
      end

      FILTRANDO: begin
        cnt_ocioso_prox = 16'd0;
        if (!enable || (s != cand)) begin
          // Bounce, change of combination or disarm: drop the candidate silently
          cnt_estavel_prox = 8'd0;
          estado_prox      = OCIOSO;
        end else if (cnt_estavel >= DB_ULTIMO) begin
          if (eh_one_hot(cand)) begin
            jogada_prox     = cand;
            tem_jogada_prox = 1'b1;
          end else begin
            invalida_prox = 1'b1;
          end
          cnt_estavel_prox = 8'd0;
          estado_prox      = ESPERA_SOLTAR;
        end else begin
          cnt_estavel_prox = cnt_estavel + 8'd1;
        end
      end

      ESPERA_SOLTAR: begin
        // enable is ignored here: a held button must be released before anything new is accepted
        cnt_ocioso_prox = 16'd0;
        if (s != 4'd0) begin
          cnt_estavel_prox = 8'd0;
        end else if (cnt_estavel >= DB_ULTIMO) begin
          cnt_estavel_prox = 8'd0;
          estado_prox      = OCIOSO;
        end else begin
          cnt_estavel_prox = cnt_estavel + 8'd1;
        end
      end

      default: begin
        cnt_estavel_prox = 8'd0;
        cnt_ocioso_prox  = 16'd0;
        estado_prox      = OCIOSO;
      end
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_condicionador_botoes.sv
// tb/tb_condicionador_botoes.sv - randomized and directed bench with a cycle reference model
module tb_condicionador_botoes;

  localparam int DB = 3;
  localparam int TO = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] botoes;
  logic [3:0] jogada;
  logic       tem_jogada;
  logic       jogada_invalida;
  logic       timeout;
  logic [1:0] db_estado;

  int erros  = 0;
  int checks = 0;
  int n_tj, n_inv, n_to;

  // Reference model: sync pipeline, phase (0 idle, 1 filtering, 2 waiting release), run lengths
  logic [3:0] m_p1, m_p2, m_cand, m_jog;
  int         m_fase, m_run, m_idle;
  logic       m_tj, m_inv, m_to;

  condicionador_botoes #(
    .DEBOUNCE_CYCLES (DB),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .botoes          (botoes),
    .jogada          (jogada),
    .tem_jogada      (tem_jogada),
    .jogada_invalida (jogada_invalida),
    .timeout         (timeout),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      erros++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
    end
  endtask

  task automatic modelo_passo(input logic r, input logic e, input logic [3:0] b);
    logic [3:0] s;
    m_tj = 0; m_inv = 0; m_to = 0;
    if (r) begin
      m_p1 = 0; m_p2 = 0; m_cand = 0; m_jog = 0;
      m_fase = 0; m_run = 0; m_idle = 0;
      return;
    end
    s = m_p2;
    m_p2 = m_p1;
    m_p1 = b;
    if (m_fase == 0) begin
      if (e && s != 0) begin
        m_cand = s; m_run = 1; m_fase = 1; m_idle = 0;
      end else if (e) begin
        m_idle++;
        if (m_idle == TO) begin
          m_to = 1; m_idle = 0;
        end
      end else begin
        m_idle = 0;
      end
    end else if (m_fase == 1) begin
      if (!e || s != m_cand) begin
        m_fase = 0; m_run = 0;
      end else begin
        m_run++;
        if (m_run == DB) begin
          if ($countones(m_cand) == 1) begin
            m_jog = m_cand; m_tj = 1;
          end else begin
            m_inv = 1;
          end
          m_fase = 2; m_run = 0;
        end
      end
    end else begin
      if (s != 0) m_run = 0;
      else begin
        m_run++;
        if (m_run == DB) begin
          m_fase = 0; m_run = 0;
        end
      end
    end
  endtask

  task automatic ciclo(input logic r, input logic e, input logic [3:0] b);
    reset = r; enable = e; botoes = b;
    @(posedge clock);
    modelo_passo(r, e, b);
    @(negedge clock);
    verifica("jogada", 32'(jogada), 32'(m_jog));
    verifica("tem_jogada", 32'(tem_jogada), 32'(m_tj));
    verifica("jogada_invalida", 32'(jogada_invalida), 32'(m_inv));
    verifica("timeout", 32'(timeout), 32'(m_to));
    verifica("db_estado", 32'(db_estado), 32'(m_fase));
    verifica("exclusivo", 32'($countones({tem_jogada, jogada_invalida, timeout}) <= 1), 32'd1);
    n_tj  += int'(tem_jogada);
    n_inv += int'(jogada_invalida);
    n_to  += int'(timeout);
  endtask

  task automatic zera_contagem();
    n_tj = 0; n_inv = 0; n_to = 0;
  endtask

  initial begin
    logic [3:0] padrao;
    int dur;
    reset = 1; enable = 0; botoes = 0;
    m_p1 = 0; m_p2 = 0; m_cand = 0; m_jog = 0;
    m_fase = 0; m_run = 0; m_idle = 0;
    m_tj = 0; m_inv = 0; m_to = 0;
    zera_contagem();
    @(negedge clock);

    // Reset state
    ciclo(1, 0, 4'b0000);
    ciclo(1, 1, 4'b1111);
    verifica("reset_jogada", 32'(jogada), 32'd0);
    verifica("reset_estado", 32'(db_estado), 32'd0);

    // Single press of 0001 for 5 cycles then release
    zera_contagem();
    for (int i = 1; i <= 5; i++) ciclo(0, 1, 4'b0001);
    verifica("s1_pulso_borda5", 32'(tem_jogada), 32'd1);
    for (int i = 1; i <= 4; i++) ciclo(0, 1, 4'b0000);
    verifica("s1_ainda_espera", 32'(db_estado), 32'd2);
    ciclo(0, 1, 4'b0000);
    verifica("s1_volta_ocioso", 32'(db_estado), 32'd0);
    for (int i = 0; i < 3; i++) ciclo(0, 1, 4'b0000);
    verifica("s1_n_tem_jogada", 32'(n_tj), 32'd1);
    verifica("s1_jogada", 32'(jogada), 32'b0001);

    // Bounce then stable 0100
    zera_contagem();
    for (int i = 0; i < 2; i++) ciclo(0, 1, 4'b0100);
    ciclo(0, 1, 4'b0000);
    for (int i = 0; i < 5; i++) ciclo(0, 1, 4'b0100);
    for (int i = 0; i < 8; i++) ciclo(0, 1, 4'b0000);
    verifica("s2_n_tem_jogada", 32'(n_tj), 32'd1);
    verifica("s2_jogada", 32'(jogada), 32'b0100);

    // Two buttons at once
    zera_contagem();
    for (int i = 0; i < 5; i++) ciclo(0, 1, 4'b0011);
    for (int i = 0; i < 8; i++) ciclo(0, 1, 4'b0000);
    verifica("s3_n_invalida", 32'(n_inv), 32'd1);
    verifica("s3_n_tem_jogada", 32'(n_tj), 32'd0);
    verifica("s3_jogada_mantida", 32'(jogada), 32'b0100);

    // Long hold, no auto-repeat
    zera_contagem();
    for (int i = 0; i < 40; i++) ciclo(0, 1, 4'b1000);
    verifica("s4_n_durante", 32'(n_tj), 32'd1);
    for (int i = 0; i < 10; i++) ciclo(0, 1, 4'b0000);
    verifica("s4_n_total", 32'(n_tj), 32'd1);
    verifica("s4_jogada", 32'(jogada), 32'b1000);

    // Idle timeout, then disarmed
    ciclo(1, 0, 4'b0000);
    zera_contagem();
    for (int i = 1; i <= 45; i++) begin
      ciclo(0, 1, 4'b0000);
      if (i == 20 || i == 40) verifica("s5_timeout_ciclo", 32'(timeout), 32'd1);
    end
    verifica("s5_n_timeout", 32'(n_to), 32'd2);
    zera_contagem();
    for (int i = 0; i < 30; i++) ciclo(0, 0, 4'b0000);
    verifica("s5_sem_timeout", 32'(n_to), 32'd0);

    // Reset in the middle of a press, then the held button is re-filtered
    zera_contagem();
    for (int i = 0; i < 2; i++) ciclo(0, 1, 4'b0010);
    ciclo(1, 1, 4'b0010);
    verifica("s6_reset_jogada", 32'(jogada), 32'd0);
    verifica("s6_reset_estado", 32'(db_estado), 32'd0);
    verifica("s6_sem_pulso", 32'(n_tj), 32'd0);
    for (int i = 0; i < 5; i++) ciclo(0, 1, 4'b0010);
    verifica("s6_pulso", 32'(tem_jogada), 32'd1);
    verifica("s6_jogada", 32'(jogada), 32'b0010);
    for (int i = 0; i < 8; i++) ciclo(0, 1, 4'b0000);

    // Randomized traffic against the model
    for (int k = 0; k < 120; k++) begin
      case ($urandom_range(0, 5))
        0, 1: padrao = 4'd0;
        2, 3: padrao = 4'(1 << $urandom_range(0, 3));
        default: padrao = 4'($urandom_range(0, 15));
      endcase
      dur = $urandom_range(1, 8);
      for (int j = 0; j < dur; j++)
        ciclo(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0), padrao);
    end

    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end

endmodule

// File: doc/condicionador_botoes.md
CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 3: consecutive stable synchronized samples required to accept a press or a release; legal range 2..255.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 5000: idle cycles with enable high before timeout fires; legal range 2..65535.
REQ-003 The block SHALL have port clock, input, 1 bit: single clock, rising edge; the block SHALL use no other clock.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-005 The block SHALL have port enable, input, 1 bit: arms detection; driven by the game control unit.
REQ-006 The block SHALL have port botoes, input, 4 bits: raw asynchronous push buttons.
REQ-007 The block SHALL have port jogada, output, 4 bits: one-hot code of the last accepted press, registered.
REQ-008 The block SHALL have port tem_jogada, output, 1 bit: one-cycle pulse on each accepted single-button press.
REQ-009 The block SHALL have port jogada_invalida, output, 1 bit: one-cycle pulse when a stable press has more than one button.
REQ-010 The block SHALL have port timeout, output, 1 bit: one-cycle pulse after TIMEOUT_CYCLES idle cycles.
REQ-011 The block SHALL have port db_estado, output, 2 bits: current FSM state code, for debug.

Function
REQ-012 The block SHALL pass botoes through a 2-flop synchronizer; the synchronizer output s SHALL be the only form of botoes used by the FSM.
REQ-013 The FSM SHALL have states OCIOSO=00, FILTRANDO=01, ESPERA_SOLTAR=10; code 11 SHALL return to OCIOSO.
REQ-014 In OCIOSO, with enable=1 and s!=0, the block SHALL capture s into cand, set the stable counter to 1, and go to FILTRANDO.
REQ-015 In FILTRANDO, if s!=cand (bounce or change), the block SHALL go to OCIOSO with no output pulse.
REQ-016 In FILTRANDO, if s==cand, the stable counter SHALL increment.
REQ-017 When the stable count reaches DEBOUNCE_CYCLES with cand one-hot, the block SHALL load jogada<=cand, pulse tem_jogada for 1 cycle, and go to ESPERA_SOLTAR.
REQ-018 When the stable count reaches DEBOUNCE_CYCLES with cand not one-hot, the block SHALL pulse jogada_invalida for 1 cycle, keep jogada unchanged, and go to ESPERA_SOLTAR.
REQ-019 Latency: counting the first edge that samples the press as edge 1, tem_jogada SHALL be high in the cycle after edge DEBOUNCE_CYCLES+2 (edge 5 with the defaults).
REQ-020 In ESPERA_SOLTAR, the block SHALL go to OCIOSO only after DEBOUNCE_CYCLES consecutive samples of s==0; any nonzero sample SHALL restart that count.
REQ-021 A button held indefinitely SHALL produce exactly one tem_jogada; no auto-repeat.
REQ-022 In OCIOSO with enable=1 and s==0, the idle counter SHALL increment.
REQ-023 At count TIMEOUT_CYCLES-1 the block SHALL pulse timeout and clear the idle counter; timeout SHALL repeat every TIMEOUT_CYCLES cycles while idle.
REQ-024 The idle counter SHALL clear on leaving OCIOSO or whenever enable=0.
REQ-025 enable=0 in FILTRANDO SHALL return the FSM to OCIOSO without a pulse.
REQ-026 enable=0 in ESPERA_SOLTAR SHALL not abort the wait for release.
REQ-027 tem_jogada, jogada_invalida and timeout SHALL be mutually exclusive in any cycle.
REQ-028 All outputs SHALL be registered.
REQ-029 Counters SHALL saturate rather than wrap.

Reset
REQ-030 On reset=1 at a rising edge, the block SHALL set the state to OCIOSO, clear the synchronizer, cand and both counters, and drive jogada=0000, tem_jogada=0, jogada_invalida=0, timeout=0, db_estado=00.
REQ-031 reset SHALL take priority over all other inputs.
REQ-032 Reset mid-press SHALL produce no pulse; a button still held after reset SHALL be re-filtered and accepted as a new press.

Structure
REQ-033 Shared package condicionador_pkg SHALL hold the state encodings and the DEBOUNCE_CYCLES/TIMEOUT_CYCLES defaults.
REQ-034 The 2-flop synchronizer SHALL be sub-module sincronizador_2ff, 4 bits wide, with synchronous reset.
REQ-035 The FSM and both counters SHALL reside in condicionador_botoes.

Verification
REQ-036 Scenario: reset pulse, then enable=1, botoes=0001 for 5 cycles then 0000 -> one tem_jogada pulse after edge 5, jogada=0001, return to OCIOSO DEBOUNCE_CYCLES+2 cycles after release.
REQ-037 Scenario: botoes=0100 for 2 cycles, 0000 for 1 cycle, 0100 for 5 cycles -> exactly one tem_jogada, jogada=0100.
REQ-038 Scenario: botoes=0011 for 5 cycles -> one jogada_invalida pulse, no tem_jogada, jogada unchanged.
REQ-039 Scenario: botoes=1000 held for 40 cycles -> single tem_jogada; none on release.
REQ-040 Scenario: TIMEOUT_CYCLES=20, enable=1, no press for 45 cycles -> timeout pulses at idle cycles 20 and 40; enable=0 -> no further pulses.
REQ-041 Scenario: reset asserted at edge 3 of a 5-cycle press of 0010 -> no pulse, all outputs zero, FSM in OCIOSO; press held 5 more cycles -> tem_jogada, jogada=0010.
